code_decoder: RTL and testbench

CODE_DECODER -- requirements
Module: code_decoder

---
 rtl/code_decoder.sv | 128 ++++++++++++
 tb/tb_code_decoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/code_decoder.sv
// Two-bit code to one-hot display decoder.
// Codes are queued in a small FIFO. Each one is shown on out0..out3 for HOLD
// cycles, followed by one blank GAP cycle and one IDLE cycle, so identical
// codes in a row stay visibly separate.
module code_decoder #(
  parameter int HOLD  = 4,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in0,
  input  logic in1,
  input  logic in_valid,
  output logic in_ready,
  output logic out0,
  output logic out1,
  output logic out2,
  output logic out3,
  output logic out_valid,
  output logic busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [7:0]    HOLD_LOAD = 8'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } state_t;

  state_t        state;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    hold;
  logic [1:0]    code;
  logic [3:0]    lines;
  logic          push;
  logic          pop;
  logic [1:0]    head;

  // in_ready looks only at the registered count. A code offered while the
  // FIFO is full is therefore dropped, even on an edge where IDLE pops.
  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (count != '0);
  assign head     = mem[rd_ptr];
  assign busy     = (count != '0) || (state != IDLE);

  assign {out3, out2, out1, out0} = lines;

  // FIFO storage. The storage array needs no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in1, in0};
    end
  end

  // FIFO pointers and occupancy. The power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Display FSM. It drives the registered one-hot lines for HOLD cycles per code.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold      <= '0;
      code      <= '0;
      lines     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            code      <= head;
            hold      <= HOLD_LOAD;
            lines     <= 4'b0001 << head;
            out_valid <= 1'b1;
            state     <= SHOW;
          end
        end
        SHOW: begin
          if (hold == 8'd0) begin
            lines     <= '0;
            out_valid <= 1'b0;
            state     <= GAP;
          end else begin
            hold      <= hold - 8'd1;
            lines     <= 4'b0001 << code;
            out_valid <= 1'b1;
          end
        end
        GAP: begin
          lines     <= '0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          lines     <= '0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_decoder.sv
// Testbench for code_decoder.
// It applies a directed table, several hand-written multi-cycle sequences and
// random traffic. Every cycle is checked against a queue-based timing model.
module tb_code_decoder;

  localparam int HOLD  = 4;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  logic in0;
  logic in1;
  logic in_valid;
  logic in_ready;
  logic out0;
  logic out1;
  logic out2;
  logic out3;
  logic out_valid;
  logic busy;

  int vectors;
  int miscompares;

  // Reference model: the queue of accepted codes, plus the position inside the
  // current display window of HOLD+2 cycles.
  int q[$];
  bit active;
  int phase;
  int cur;

  typedef struct {
    logic       r;
    logic       v;
    logic [1:0] c;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[8];

  code_decoder #(.HOLD(HOLD), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0       (in0),
    .in1       (in1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .busy      (busy)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advances the model by one rising edge, using the inputs seen at that edge.
  function automatic void model_edge(input logic r, input logic v, input logic [1:0] c);
    bit ready;
    if (r) begin
      q.delete();
      active = 0;
      phase  = 0;
      cur    = 0;
      return;
    end
    ready = (q.size() != DEPTH);
    if ((!active || phase == HOLD + 1) && q.size() > 0) begin
      cur    = q.pop_front();
      active = 1;
      phase  = 0;
    end else if (active) begin
      if (phase == HOLD + 1) active = 0;
      else phase++;
    end
    if (v && ready) q.push_back(int'(c));
  endfunction

  // Packs the expected outputs as {out3,out2,out1,out0,out_valid,in_ready,busy}.
  function automatic logic [6:0] model_expect();
    logic       show;
    logic [3:0] lines;
    logic       rdy;
    logic       bsy;
    show  = active && (phase < HOLD);
    lines = show ? (4'b0001 << cur) : 4'b0000;
    rdy   = (q.size() != DEPTH);
    bsy   = (q.size() != 0) || (active && phase <= HOLD);
    return {lines, show, rdy, bsy};
  endfunction

  task automatic check_output(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = {out3, out2, out1, out0, out_valid, in_ready, busy};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at t=%0t: got {out3..0,valid,ready,busy}=%b, expected %b",
               name, $time, got, exp);
    end
  endtask

  // Drives one cycle of inputs, advances the model and checks the outputs
  // on the following falling edge.
  task automatic apply_stimulus(input logic r, input logic v, input logic [1:0] c);
    rst      = r;
    in_valid = v;
    {in1, in0} = c;
    @(posedge clk);
    model_edge(r, v, c);
    @(negedge clk);
    check_output("model", model_expect());
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    active      = 0;
    phase       = 0;
    cur         = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in0         = 1'b0;
    in1         = 1'b0;

    // Single push of code 10: reset, push, 4 cycles of out2, GAP, then idle.
    tbl[0] = '{1'b1, 1'b0, 2'b00, 7'b0000_0_1_0};
    tbl[1] = '{1'b0, 1'b1, 2'b10, 7'b0000_0_1_1};
    tbl[2] = '{1'b0, 1'b0, 2'b00, 7'b0100_1_1_1};
    tbl[3] = '{1'b0, 1'b0, 2'b00, 7'b0100_1_1_1};
    tbl[4] = '{1'b0, 1'b0, 2'b00, 7'b0100_1_1_1};
    tbl[5] = '{1'b0, 1'b0, 2'b00, 7'b0100_1_1_1};
    tbl[6] = '{1'b0, 1'b0, 2'b00, 7'b0000_0_1_1};
    tbl[7] = '{1'b0, 1'b0, 2'b00, 7'b0000_0_1_0};

    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(tbl[i].r, tbl[i].v, tbl[i].c);
      check_output($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // Four distinct codes on consecutive edges.
    apply_stimulus(1'b0, 1'b1, 2'b00);
    apply_stimulus(1'b0, 1'b1, 2'b01);
    apply_stimulus(1'b0, 1'b1, 2'b10);
    apply_stimulus(1'b0, 1'b1, 2'b11);
    idle_cycles(26);

    // in_valid held high for 10 cycles: the FIFO fills and extra codes are dropped.
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1, 2'b11);
    idle_cycles(32);

    // Identical codes back-to-back stay separated by a GAP cycle.
    apply_stimulus(1'b0, 1'b1, 2'b01);
    apply_stimulus(1'b0, 1'b1, 2'b01);
    idle_cycles(14);

    // Reset in the middle of SHOW with three codes still queued.
    apply_stimulus(1'b0, 1'b1, 2'b00);
    apply_stimulus(1'b0, 1'b1, 2'b01);
    apply_stimulus(1'b0, 1'b1, 2'b10);
    apply_stimulus(1'b0, 1'b1, 2'b11);
    apply_stimulus(1'b1, 1'b1, 2'b01);
    check_output("reset_mid_show", 7'b0000_0_1_0);
    idle_cycles(12);

    // Fill the FIFO during a display, then keep offering a code across the pop edge.
    apply_stimulus(1'b0, 1'b1, 2'b00);
    apply_stimulus(1'b0, 1'b1, 2'b01);
    apply_stimulus(1'b0, 1'b1, 2'b10);
    apply_stimulus(1'b0, 1'b1, 2'b11);
    apply_stimulus(1'b0, 1'b1, 2'b01);
    check_output("full_not_ready", 7'b0001_1_0_1);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b1, 2'b10);
    idle_cycles(36);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
                     2'($urandom_range(0, 3)));
    end
    idle_cycles(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
